// File: rtl/alu_defs.sv
// Shared execute-stage arithmetic definitions.
// Holds the remainder-unit state encoding and its default operand width.
package alu_defs;

  localparam int MOD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    MOD_IDLE,
    MOD_RUN,
    MOD_DONE
  } mod_state_t;

endpackage

// File: rtl/mod_step.sv
// One restoring shift-subtract iteration of the remainder engine.
// Ports: r (partial remainder), qbit (next dividend bit), d (divisor) -> r_next.
module mod_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r,
  input  logic             qbit,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next
);

  // One guard bit above the shifted remainder exposes the borrow.
  // r[WIDTH] is always 0 between iterations, so this equals
  // {1'b0, r[WIDTH-1:0], qbit}.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  assign w_shift = {r, qbit};
  assign w_diff  = w_shift - {2'b00, d};
  assign w_neg   = w_diff[WIDTH+1];
  assign r_next  = w_neg ? w_shift[WIDTH:0] : w_diff[WIDTH:0];

endmodule

// File: rtl/mod_iter_unit.sv
// Multi-cycle unsigned remainder (a mod b), one bit per cycle.
// Ports: clk, rst, start, a, b -> busy, done, rem, div_by_zero.
module mod_iter_unit
  import alu_defs::*;
#(
  parameter int WIDTH = MOD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  mod_state_t       r_state;
  mod_state_t       w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic [WIDTH:0]   w_r_next;
  logic             w_accept;
  logic             w_bzero;
  logic             w_last;

  assign w_accept = start && (r_state != MOD_RUN);
  assign w_bzero  = (b == '0);
  assign w_last   = (r_cnt == '0);

  mod_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .qbit   (r_q[WIDTH-1]),
    .d      (r_d),
    .r_next (w_r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= MOD_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MOD_IDLE, MOD_DONE: begin
        if (start) w_next = w_bzero ? MOD_DONE : MOD_RUN;
        else       w_next = MOD_IDLE;
      end
      MOD_RUN: begin
        if (w_last) w_next = MOD_DONE;
      end
      default: w_next = MOD_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == MOD_RUN);
    done = (r_state == MOD_DONE);
  end

  // Result registers only change when a result is produced,
  // so rem/div_by_zero stay valid for execute after done drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_d   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_q   <= a;
      r_d   <= b;
      r_r   <= '0;
      r_cnt <= CW'(WIDTH - 1);
      if (w_bzero) begin
        r_rem <= a;
        r_dbz <= 1'b1;
      end
    end else if (r_state == MOD_RUN) begin
      r_r   <= w_r_next;
      r_q   <= r_q << 1;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_rem <= w_r_next[WIDTH-1:0];
        r_dbz <= 1'b0;
      end
    end
  end

  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mod_iter_unit.sv
// Directed and randomized checks for mod_iter_unit.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_mod_iter_unit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int n_chk;
  int n_err;

  mod_iter_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (on falling edges) until done; cyc counts cycles since the
  // accepting edge, nb counts busy cycles seen, ov flags busy&done.
  task automatic wait_done(input int cyc0, output int cyc,
                           output int nb, output int ov);
    cyc = cyc0;
    nb  = 0;
    ov  = 0;
    while (!done && cyc < 64) begin
      if (busy) nb++;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) ov = 1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] er,
                        input logic edbz);
    int cyc, nb, ov;
    issue(ia, ib);
    wait_done(1, cyc, nb, ov);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), (ib == 0) ? 32'd1 : 32'(W + 1));
    chk({tag, "_busy"}, 32'(nb), (ib == 0) ? 32'd0 : 32'(W));
    chk({tag, "_ovl"}, 32'(ov), 32'd0);
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, nb, ov, seen;
    logic [W-1:0] ra, rb, er;
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'd5;
    b     = 16'd0;

    // reset wins over start
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", {28'd0, busy, done, div_by_zero, 1'b0} | 32'(rem),
          32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_out", {30'd0, busy, done}, 32'd0);

    run_op("m100_7", 16'd100, 16'd7, 16'd2, 1'b0);
    run_op("dbz", 16'd5, 16'd0, 16'd5, 1'b1);
    run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd0, 1'b0);
    run_op("ffff_1", 16'hFFFF, 16'd1, 16'd0, 1'b0);
    run_op("m3_9", 16'd3, 16'd9, 16'd3, 1'b0);
    run_op("ffff_2", 16'hFFFF, 16'd2, 16'd1, 1'b0);

    // start mid-RUN ignored, start in DONE accepted
    issue(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    issue(16'd3, 16'd9);
    wait_done(6, cyc, nb, ov);
    chk("ign_lat", 32'(cyc), 32'(W + 1));
    chk("ign_rem", 32'(rem), 32'd2);
    issue(16'd61, 16'd10);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1, cyc, nb, ov);
    chk("b2b_lat", 32'(cyc), 32'(W + 1));
    chk("b2b_rem", 32'(rem), 32'd1);
    @(negedge clk);

    // reset mid-operation aborts
    issue(16'd500, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    run_op("m1000_37", 16'd1000, 16'd37, 16'd1, 1'b0);

    // randomized scoreboard
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = (i % 8 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      er = (rb == 0) ? ra : ra % rb;
      issue(ra, rb);
      wait_done(1, cyc, nb, ov);
      chk("rnd_rem", 32'(rem), 32'(er));
      chk("rnd_dbz", 32'(div_by_zero), 32'(rb == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
